// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and helpers for the data cache
// Purpose: FSM state type, address-split width functions and byte pack/unpack
//          helpers between 32-bit words and the big-endian 8x[0:3] memory bus.
// Ports:   none (package).
package dcache_pkg;

   typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

   // Element [0] is the most significant byte (bits 31:24).
   typedef logic [0:3][7:0] bytes4_t;

   function automatic int idx_w(input int lines);
      return $clog2(lines);
   endfunction

   // Word address is 30 bits; whatever the index does not use is tag.
   function automatic int tag_w(input int lines);
      return 30 - $clog2(lines);
   endfunction

   function automatic bytes4_t word_to_bytes(input logic [31:0] w);
      bytes4_t b;
      for (int i = 0; i < 4; i++) b[i] = w[31-8*i -: 8];
      return b;
   endfunction

   function automatic logic [31:0] bytes_to_word(input bytes4_t b);
      logic [31:0] w;
      for (int i = 0; i < 4; i++) w[31-8*i -: 8] = b[i];
      return w;
   endfunction

endpackage

// File: rtl/dcache_if.sv
// rtl/dcache_if.sv - core-side and memory-side bus of the data cache
// Purpose: bundles the load/store request bus from the core and the
//          fixed-latency memory bus. slave = cache, master = core + memory.
// Signals: cpu_addr/cpu_rd_en/cpu_wr_en/cpu_wdata in, cpu_rdata/cpu_ready out;
//          mem_addr/mem_data_in/mem_write_en out, mem_data_out in.
interface dcache_if;
   import dcache_pkg::*;

   logic [31:0] cpu_addr;
   logic        cpu_rd_en;
   logic        cpu_wr_en;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_ready;
   logic [31:0] mem_addr;
   bytes4_t     mem_data_in;
   bytes4_t     mem_data_out;
   logic        mem_write_en;

   modport slave (
      input  cpu_addr, cpu_rd_en, cpu_wr_en, cpu_wdata, mem_data_out,
      output cpu_rdata, cpu_ready, mem_addr, mem_data_in, mem_write_en
   );

   modport master (
      output cpu_addr, cpu_rd_en, cpu_wr_en, cpu_wdata, mem_data_out,
      input  cpu_rdata, cpu_ready, mem_addr, mem_data_in, mem_write_en
   );

endinterface

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - tag/valid/data storage of the direct-mapped cache
// Purpose: LINES one-word lines with one combinational read port, one
//          synchronous write port and an asynchronous clear of all valid bits.
// Ports:   clk, rst_b (async active-low, clears valid);
//          ridx -> rvalid/rtag/rdata (combinational read);
//          we/widx/wtag/wdata (write line and set valid at clk rise).
module dcache_array
   import dcache_pkg::*;
#(
   parameter int LINES = 64
) (
   input  logic                        clk,
   input  logic                        rst_b,
   input  logic [idx_w(LINES)-1:0]     ridx,
   output logic                        rvalid,
   output logic [tag_w(LINES)-1:0]     rtag,
   output logic [31:0]                 rdata,
   input  logic                        we,
   input  logic [idx_w(LINES)-1:0]     widx,
   input  logic [tag_w(LINES)-1:0]     wtag,
   input  logic [31:0]                 wdata
);

   logic [LINES-1:0]         valid_q;
   logic [LINES-1:0]         valid_d;
   logic [tag_w(LINES)-1:0]  tag_q  [LINES];
   logic [31:0]              data_q [LINES];

   always_comb begin
      valid_d = valid_q;
      if (we) valid_d[widx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) valid_q <= '0;
      else        valid_q <= valid_d;
   end

   // Tag/data need no reset: they are never observed while valid is 0.
   always_ff @(posedge clk) begin
      if (we) begin
         tag_q[widx]  <= wtag;
         data_q[widx] <= wdata;
      end
   end

   assign rvalid = valid_q[ridx];
   assign rtag   = tag_q[ridx];
   assign rdata  = data_q[ridx];

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-through write-allocate data cache
// Purpose: serves core loads in zero extra cycles on a hit, fetches a word on
//          a load miss (MEM_LATENCY cycles in RD_MISS) and writes every store
//          through to memory (MEM_LATENCY cycles in WR_THRU), allocating it.
// Ports:   clk, rst_b (async active-low); bus (dcache_if.slave);
//          hit_count/miss_count outputs only when DCACHE_STATS_EN is defined.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int LINES       = 64,
   parameter int MEM_LATENCY = 4
) (
   input  logic        clk,
   input  logic        rst_b,
   dcache_if.slave     bus
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int IW = idx_w(LINES);
   localparam int TW = tag_w(LINES);
   localparam int CW = $clog2(MEM_LATENCY + 1);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [29:0]     addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic            mem_we_q, mem_we_d;

   logic            rvalid;
   logic [TW-1:0]   rtag;
   logic [31:0]     rdata;
   logic            hit;
   logic            last;
   logic            ready_c;
   logic            arr_we;
   logic [31:0]     arr_wdata;
   logic            unused_addr_bits;

   assign unused_addr_bits = ^bus.cpu_addr[1:0];

   dcache_array #(.LINES(LINES)) u_array (
      .clk   (clk),
      .rst_b (rst_b),
      .ridx  (bus.cpu_addr[2 +: IW]),
      .rvalid(rvalid),
      .rtag  (rtag),
      .rdata (rdata),
      .we    (arr_we),
      .widx  (addr_q[IW-1:0]),
      .wtag  (addr_q[29 -: TW]),
      .wdata (arr_wdata)
   );

   assign hit  = rvalid && (rtag == bus.cpu_addr[31 -: TW]);
   assign last = (cnt_q == CW'(MEM_LATENCY - 1));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      mem_we_d  = mem_we_q;
      arr_we    = 1'b0;
      arr_wdata = wdata_q;
      ready_c   = 1'b0;
      case (state_q)
         IDLE: begin
            // Store wins over a simultaneous load.
            if (bus.cpu_wr_en) begin
               addr_d   = bus.cpu_addr[31:2];
               wdata_d  = bus.cpu_wdata;
               mem_we_d = 1'b1;
               cnt_d    = '0;
               state_d  = WR_THRU;
            end else if (bus.cpu_rd_en && !hit) begin
               addr_d   = bus.cpu_addr[31:2];
               cnt_d    = '0;
               state_d  = RD_MISS;
            end else begin
               ready_c  = 1'b1;
            end
         end
         RD_MISS: begin
            if (last) begin
               arr_we    = 1'b1;
               arr_wdata = bytes_to_word(bus.mem_data_out);
               cnt_d     = '0;
               state_d   = IDLE;
            end else begin
               cnt_d     = cnt_q + 1'b1;
            end
         end
         WR_THRU: begin
            if (last) begin
               arr_we   = 1'b1;
               ready_c  = 1'b1;
               mem_we_d = 1'b0;
               cnt_d    = '0;
               state_d  = IDLE;
            end else begin
               cnt_d    = cnt_q + 1'b1;
            end
         end
         default: begin
            mem_we_d = 1'b0;
            cnt_d    = '0;
            state_d  = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         mem_we_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         mem_we_q <= mem_we_d;
      end
   end

   // Ready is forced low while reset is held, even though the state is IDLE.
   assign bus.cpu_ready    = ready_c && rst_b;
   assign bus.cpu_rdata    = (state_q == IDLE && bus.cpu_rd_en && !bus.cpu_wr_en && hit)
                             ? rdata : 32'h0;
   assign bus.mem_addr     = {addr_q, 2'b00};
   assign bus.mem_data_in  = word_to_bytes(wdata_q);
   assign bus.mem_write_en = mem_we_q;

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count_q, hit_count_d;
   logic [31:0] miss_count_q, miss_count_d;
   logic        rd_only;

   assign rd_only = (state_q == IDLE) && bus.cpu_rd_en && !bus.cpu_wr_en;

   always_comb begin
      hit_count_d  = hit_count_q  + {31'h0, rd_only &&  hit};
      miss_count_d = miss_count_q + {31'h0, rd_only && !hit};
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - self-checking bench for dcache_ctrl
module tb_dcache_ctrl;
   import dcache_pkg::*;

   localparam int LINES = 64;
   localparam int ML    = 4;

   logic clk = 1'b0;
   logic rst_b;
   always #5 clk = ~clk;

   dcache_if bus();

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   dcache_ctrl #(.LINES(LINES), .MEM_LATENCY(ML)) dut (
      .clk  (clk),
      .rst_b(rst_b),
      .bus  (bus)
`ifdef DCACHE_STATS_EN
      ,
      .hit_count (hit_count),
      .miss_count(miss_count)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Environment memory: 4 KiB byte array, big-endian words.
   logic [7:0] mem_b [0:4095];

   function automatic logic [31:0] init_word(input int w);
      if (w == 64) return 32'hDEADBEEF;
      return (w * 32'h9E3779B1) ^ 32'h0BADF00D;
   endfunction

   initial begin : memory
      logic [31:0] v;
      for (int w = 0; w < 1024; w++) begin
         v = init_word(w);
         for (int i = 0; i < 4; i++) mem_b[4*w+i] = v[31-8*i -: 8];
      end
      forever begin
         @(negedge clk);
         if (bus.mem_write_en === 1'b1)
            for (int i = 0; i < 4; i++)
               mem_b[int'(bus.mem_addr[11:0]) + i] = bus.mem_data_in[i];
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++)
         bus.mem_data_out[i] = mem_b[int'(bus.mem_addr[11:0]) + i];
   end

   // Reference model: what the cache holds (index -> tag) and what memory must hold.
   logic [31:0] ref_mem [0:1023];
   logic        mvalid  [0:LINES-1];
   logic [23:0] mtag    [0:LINES-1];

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
      end
   endtask

   // Issues one request at posedge+1 and checks every cycle until it completes.
   // kind 0 = load hit, 1 = load miss, 2 = store.
   task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit scr,
                         output int st, output int wec,
                         output logic [31:0] rdat, output logic [31:0] din);
      int idx, w, kind, rc;
      logic [23:0] tag;
      idx  = int'(addr[7:2]);
      w    = int'(addr[11:2]);
      tag  = addr[31:8];
      if (wr)                                   kind = 2;
      else if (mvalid[idx] && mtag[idx] == tag) kind = 0;
      else                                      kind = 1;
      rc = (kind == 0) ? 0 : (kind == 1) ? ML + 1 : ML;
      bus.cpu_rd_en = rd;
      bus.cpu_wr_en = wr;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wdata;
      st = 0; wec = 0; rdat = 'x; din = 'x;
      for (int k = 0; k <= rc; k++) begin
         if (scr && k >= 1 && k <= ML) begin
            bus.cpu_addr  = $urandom;
            bus.cpu_wdata = $urandom;
         end
         if (kind == 1 && k == rc) bus.cpu_addr = addr;
         @(negedge clk);
         chk("cpu_ready", {31'h0, bus.cpu_ready}, {31'h0, k == rc});
         chk("mem_write_en", {31'h0, bus.mem_write_en}, {31'h0, kind == 2 && k >= 1});
         if (kind != 0 && k >= 1 && k <= ML)
            chk("mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
         if (kind == 2 && k >= 1)
            chk("mem_data_in", bus.mem_data_in, wdata);
         if (kind != 2 && k == rc)
            chk("cpu_rdata", bus.cpu_rdata, ref_mem[w]);
         if (!bus.cpu_ready) st++;
         if (bus.mem_write_en) begin
            wec++;
            din = bus.mem_data_in;
         end
         if (k == rc) rdat = bus.cpu_rdata;
         @(posedge clk);
         #1;
      end
      if (kind == 2) ref_mem[w] = wdata;
      if (kind != 0) begin
         mvalid[idx] = 1'b1;
         mtag[idx]   = tag;
      end
   endtask

   task automatic idle_cycle();
      bus.cpu_rd_en = 1'b0;
      bus.cpu_wr_en = 1'b0;
      @(negedge clk);
      chk("idle_ready", {31'h0, bus.cpu_ready}, 32'h1);
      chk("idle_we", {31'h0, bus.mem_write_en}, 32'h0);
      @(posedge clk);
      #1;
   endtask

   initial begin : main
      int st, wec;
      logic [31:0] rd_o, din_o, a, d;
      bytes4_t bb;
      int w, r;

      for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
      for (int i = 0; i < LINES; i++) begin
         mvalid[i] = 1'b0;
         mtag[i]   = '0;
      end
      rst_b = 1'b0;
      bus.cpu_rd_en = 1'b1;
      bus.cpu_wr_en = 1'b0;
      bus.cpu_addr  = 32'h100;
      bus.cpu_wdata = 32'h0;

      // Reset values
      #12;
      chk("rst_ready", {31'h0, bus.cpu_ready}, 32'h0);
      chk("rst_we", {31'h0, bus.mem_write_en}, 32'h0);
      chk("rst_mem_addr", bus.mem_addr, 32'h0);
      chk("rst_rdata", bus.cpu_rdata, 32'h0);
      @(posedge clk);
      #1;
      rst_b = 1'b1;
      bus.cpu_rd_en = 1'b0;

      // 1: load miss then hit
      do_req(1, 0, 32'h100, 0, 0, st, wec, rd_o, din_o);
      chk("t1_miss_stall", st, 32'd5);
      chk("t1_miss_rdata", rd_o, 32'hDEADBEEF);
      do_req(1, 0, 32'h100, 0, 0, st, wec, rd_o, din_o);
      chk("t1_hit_stall", st, 32'd0);
      chk("t1_hit_rdata", rd_o, 32'hDEADBEEF);

      // 2: store write-through then hit
      do_req(0, 1, 32'h104, 32'h12345678, 0, st, wec, rd_o, din_o);
      chk("t2_we_cycles", wec, 32'd4);
      chk("t2_stall", st, 32'd4);
      bb = din_o;
      chk("t2_byte0", {24'h0, bb[0]}, 32'h12);
      chk("t2_byte3", {24'h0, bb[3]}, 32'h78);
      do_req(1, 0, 32'h104, 0, 0, st, wec, rd_o, din_o);
      chk("t2_hit_stall", st, 32'd0);
      chk("t2_hit_rdata", rd_o, 32'h12345678);

      // 3: aliasing eviction
      do_req(1, 0, 32'h200, 0, 0, st, wec, rd_o, din_o);
      chk("t3_alias_stall", st, 32'd5);
      do_req(1, 0, 32'h100, 0, 0, st, wec, rd_o, din_o);
      chk("t3_reload_stall", st, 32'd5);
      chk("t3_reload_rdata", rd_o, 32'hDEADBEEF);

      // 4: address changes during RD_MISS are ignored
      do_req(1, 0, 32'h300, 0, 1, st, wec, rd_o, din_o);
      chk("t4_miss_stall", st, 32'd5);
      do_req(1, 0, 32'h300, 0, 0, st, wec, rd_o, din_o);
      chk("t4_hit_stall", st, 32'd0);
      idle_cycle();

      // 5: reset in cycle 2 of WR_THRU
      bus.cpu_wr_en = 1'b1;
      bus.cpu_rd_en = 1'b0;
      bus.cpu_addr  = 32'h140;
      bus.cpu_wdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_b = 1'b0;
      bus.cpu_wr_en = 1'b0;
      #1;
      chk("t5_we_drop", {31'h0, bus.mem_write_en}, 32'h0);
      chk("t5_ready_rst", {31'h0, bus.cpu_ready}, 32'h0);
      @(posedge clk); #1;
      rst_b = 1'b1;
      for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
      ref_mem[32'h140 >> 2] = {mem_b[32'h140], mem_b[32'h141], mem_b[32'h142], mem_b[32'h143]};
      idle_cycle();

`ifdef DCACHE_STATS_EN
      // 6: statistics
      chk("t6_hits_rst", hit_count, 32'd0);
      chk("t6_miss_rst", miss_count, 32'd0);
      do_req(1, 0, 32'h104, 0, 0, st, wec, rd_o, din_o);
      do_req(1, 0, 32'h104, 0, 0, st, wec, rd_o, din_o);
      chk("t6_hits", hit_count, 32'd2);
      chk("t6_misses", miss_count, 32'd1);
      do_req(0, 1, 32'h108, 32'h0F0F0F0F, 0, st, wec, rd_o, din_o);
      chk("t6_hits_st", hit_count, 32'd2);
      chk("t6_misses_st", miss_count, 32'd1);
`endif

      // Post-reset loads all miss
      do_req(1, 0, 32'h100, 0, 0, st, wec, rd_o, din_o);
      chk("t5_post_miss0", st, 32'd5);
      do_req(1, 0, 32'h140, 0, 0, st, wec, rd_o, din_o);
      chk("t5_post_miss1", st, 32'd5);

      // Randomized traffic with heavy index aliasing
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 1) == 0)
            w = $urandom_range(0, 3) * 64 + $urandom_range(0, 3);
         else
            w = $urandom_range(0, 1023);
         a = {20'h0, 10'(w), 2'(($urandom_range(0, 3)))};
         if ($urandom_range(0, 7) == 0) a[31] = 1'b1;
         d = $urandom;
         r = $urandom_range(0, 9);
         if (r <= 4)      do_req(1, 0, a, d, $urandom_range(0, 1) == 1, st, wec, rd_o, din_o);
         else if (r <= 7) do_req(0, 1, a, d, $urandom_range(0, 1) == 1, st, wec, rd_o, din_o);
         else if (r == 8) do_req(1, 1, a, d, 0, st, wec, rd_o, din_o);
         else             idle_cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
